// File: rtl/fire_ifm_streamer_if.sv
// Bus bundle between the feature-map streamer, its source RAM and the squeeze MAC array.
// The master modport is the streamer's view; the slave modport is the RAM/consumer view.
interface fire_ifm_streamer_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 18
);
    logic              start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_rdata;
    logic [WIDTH-1:0]  ifm;
    logic              ifm_valid;
    logic              ifm_last_ch;
    logic              gap;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_rdata,
        output mem_rd_en, mem_addr, ifm, ifm_valid, ifm_last_ch, gap, busy, done
    );

    modport slave (
        output start, mem_rdata,
        input  mem_rd_en, mem_addr, ifm, ifm_valid, ifm_last_ch, gap, busy, done
    );
endinterface

// File: rtl/fire_ifm_streamer.sv
// Streams a W_IN x H_IN x CHIN feature map (channel fastest) out of a synchronous RAM,
// one value per cycle with a single idle gap cycle after every pixel.
module fire_ifm_streamer #(
    parameter int WIDTH  = 16,
    parameter int W_IN   = 32,
    parameter int H_IN   = 32,
    parameter int CHIN   = 256,
    parameter int ADDR_W = $clog2(W_IN * H_IN * CHIN)
) (
    input  logic                clk,
    input  logic                rst,
    fire_ifm_streamer_if.master bus
);
    localparam int CH_W  = $clog2(CHIN);
    localparam int COL_W = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam int ROW_W = (H_IN > 1) ? $clog2(H_IN) : 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHIN - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(W_IN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H_IN - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        GAP,
        DRAIN
    } state_e;

    state_e             state_q,       state_d;
    logic [CH_W-1:0]    ch_q,          ch_d;
    logic [COL_W-1:0]   col_q,         col_d;
    logic [ROW_W-1:0]   row_q,         row_d;
    logic               drain_q,       drain_d;
    logic               mem_rd_en_q,   mem_rd_en_d;
    logic [ADDR_W-1:0]  mem_addr_q,    mem_addr_d;
    logic               busy_q,        busy_d;
    logic               done_q,        done_d;
    logic               s1_valid_q,    s1_valid_d;
    logic               s1_last_q,     s1_last_d;
    logic               s1_gap_q,      s1_gap_d;
    logic [WIDTH-1:0]   ifm_q,         ifm_d;
    logic               ifm_valid_q,   ifm_valid_d;
    logic               ifm_last_ch_q, ifm_last_ch_d;
    logic               gap_q,         gap_d;

    always_comb begin : fsm_next
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        ch_d        = ch_q;
        col_d       = col_q;
        row_d       = row_q;
        drain_d     = drain_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the old frame and is dropped.
                if (bus.start && !done_q) begin
                    state_d     = READ;
                    ch_d        = '0;
                    col_d       = '0;
                    row_d       = '0;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = '0;
                    busy_d      = 1'b1;
                end
            end
            READ: begin
                if (ch_q == CH_LAST) begin
                    state_d = GAP;
                    ch_d    = '0;
                end else begin
                    ch_d        = ch_q + CH_W'(1);
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                end
            end
            GAP: begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
                if (col_q == COL_LAST && row_q == ROW_LAST) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    // Address order is linear, so the next pixel continues from the last read.
                    state_d     = READ;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = IDLE;
                    drain_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : pipe_next
        // Stage 1 tags the read issued this cycle; stage 2 pairs the tag with the RAM data.
        s1_valid_d    = mem_rd_en_q;
        s1_last_d     = mem_rd_en_q && (ch_q == CH_LAST);
        s1_gap_d      = (state_q == GAP);
        ifm_valid_d   = s1_valid_q;
        ifm_last_ch_d = s1_last_q;
        gap_d         = s1_gap_q;
        ifm_d         = s1_valid_q ? bus.mem_rdata : ifm_q;
    end

    always_ff @(posedge clk or negedge rst) begin : regs
        if (!rst) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            col_q         <= '0;
            row_q         <= '0;
            drain_q       <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_gap_q      <= 1'b0;
            ifm_q         <= '0;
            ifm_valid_q   <= 1'b0;
            ifm_last_ch_q <= 1'b0;
            gap_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
            state_q       <= state_d;
            ch_q          <= ch_d;
            col_q         <= col_d;
            row_q         <= row_d;
            drain_q       <= drain_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            s1_valid_q    <= s1_valid_d;
            s1_last_q     <= s1_last_d;
            s1_gap_q      <= s1_gap_d;
            ifm_q         <= ifm_d;
            ifm_valid_q   <= ifm_valid_d;
            ifm_last_ch_q <= ifm_last_ch_d;
            gap_q         <= gap_d;
        end
    end

    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.ifm         = ifm_q;
    assign bus.ifm_valid   = ifm_valid_q;
    assign bus.ifm_last_ch = ifm_last_ch_q;
    assign bus.gap         = gap_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_fire_ifm_streamer.sv
// Directed bench for fire_ifm_streamer: a 2x2x4 frame checked cycle by cycle and an
// 8x8x256 frame checked by aggregate counts; both RAM models return data equal to address.
module tb_fire_ifm_streamer;
    localparam int W_S = 2;
    localparam int H_S = 2;
    localparam int C_S = 4;
    localparam int A_S = $clog2(W_S * H_S * C_S);
    localparam int T_S = W_S * H_S * (C_S + 1);

    localparam int W_B = 8;
    localparam int H_B = 8;
    localparam int C_B = 256;
    localparam int A_B = $clog2(W_B * H_B * C_B);
    localparam int T_B = W_B * H_B * (C_B + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fire_ifm_streamer_if #(.WIDTH(16), .ADDR_W(A_S)) ifs ();
    fire_ifm_streamer_if #(.WIDTH(16), .ADDR_W(A_B)) ifb ();

    fire_ifm_streamer #(
        .WIDTH(16), .W_IN(W_S), .H_IN(H_S), .CHIN(C_S), .ADDR_W(A_S)
    ) u_small (
        .clk(clk),
        .rst(rst),
        .bus(ifs.master)
    );

    fire_ifm_streamer #(
        .WIDTH(16), .W_IN(W_B), .H_IN(H_B), .CHIN(C_B), .ADDR_W(A_B)
    ) u_big (
        .clk(clk),
        .rst(rst),
        .bus(ifb.master)
    );

    always @(posedge clk) if (ifs.mem_rd_en) ifs.mem_rdata <= 16'(ifs.mem_addr);
    always @(posedge clk) if (ifb.mem_rd_en) ifb.mem_rdata <= 16'(ifb.mem_addr);

    // Caller drives start=1 at a falling edge; this walks cycles 1..T_S+4 after the
    // accepting edge, optionally re-pulsing start at cycles extra_a / extra_b.
    task automatic run_frame(input string tag, input int extra_a, input int extra_b);
        int j;
        int r;
        logic exp_rd, exp_v, exp_l, exp_g, exp_busy, exp_done;
        logic [A_S-1:0] exp_addr;
        logic [15:0]    exp_ifm;
        for (int k = 1; k <= T_S + 4; k++) begin
            @(negedge clk);
            ifs.start = (k == extra_a) || (k == extra_b);
            j        = k - 1;
            r        = j % (C_S + 1);
            exp_rd   = (j < T_S) && (r < C_S);
            exp_addr = A_S'((j / (C_S + 1)) * C_S + r);
            exp_busy = (k <= T_S + 2);
            exp_done = (k == T_S + 3);
            n_vec++;
            if (ifs.mem_rd_en !== exp_rd) begin
                n_err++;
                $display("FAIL %s cycle %0d mem_rd_en: got %0b, expected %0b", tag, k, ifs.mem_rd_en, exp_rd);
            end
            if (exp_rd) begin
                n_vec++;
                if (ifs.mem_addr !== exp_addr) begin
                    n_err++;
                    $display("FAIL %s cycle %0d mem_addr: got %0d, expected %0d", tag, k, ifs.mem_addr, exp_addr);
                end
            end
            n_vec++;
            if (ifs.busy !== exp_busy) begin
                n_err++;
                $display("FAIL %s cycle %0d busy: got %0b, expected %0b", tag, k, ifs.busy, exp_busy);
            end
            n_vec++;
            if (ifs.done !== exp_done) begin
                n_err++;
                $display("FAIL %s cycle %0d done: got %0b, expected %0b", tag, k, ifs.done, exp_done);
            end
            j       = k - 3;
            exp_v   = 1'b0;
            exp_l   = 1'b0;
            exp_g   = 1'b0;
            exp_ifm = '0;
            if (j >= 0 && j < T_S) begin
                r       = j % (C_S + 1);
                exp_v   = (r < C_S);
                exp_l   = (r == C_S - 1);
                exp_g   = (r == C_S);
                exp_ifm = 16'((j / (C_S + 1)) * C_S + (exp_g ? C_S - 1 : r));
                n_vec++;
                if (ifs.ifm !== exp_ifm) begin
                    n_err++;
                    $display("FAIL %s cycle %0d ifm: got %0d, expected %0d", tag, k, ifs.ifm, exp_ifm);
                end
            end
            n_vec++;
            if (ifs.ifm_valid !== exp_v) begin
                n_err++;
                $display("FAIL %s cycle %0d ifm_valid: got %0b, expected %0b", tag, k, ifs.ifm_valid, exp_v);
            end
            n_vec++;
            if (ifs.ifm_last_ch !== exp_l) begin
                n_err++;
                $display("FAIL %s cycle %0d ifm_last_ch: got %0b, expected %0b", tag, k, ifs.ifm_last_ch, exp_l);
            end
            n_vec++;
            if (ifs.gap !== exp_g) begin
                n_err++;
                $display("FAIL %s cycle %0d gap: got %0b, expected %0b", tag, k, ifs.gap, exp_g);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        ifs.start = 1'b0;
        ifb.start = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        obs = {ifs.mem_rd_en, ifs.mem_addr, ifs.ifm, ifs.ifm_valid, ifs.ifm_last_ch,
               ifs.gap, ifs.busy, ifs.done, 4'b0};
        n_vec++;
        if (obs !== 32'd0) begin
            n_err++;
            $display("FAIL reset_small outputs: got %h, expected 0", obs);
        end
        n_vec++;
        if ({ifb.mem_rd_en, ifb.mem_addr, ifb.busy, ifb.done, ifb.ifm_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_big outputs: got nonzero, expected 0");
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ifs.mem_rd_en, ifs.busy, ifs.done} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset rd_en/busy/done: got %b, expected 000",
                     {ifs.mem_rd_en, ifs.busy, ifs.done});
        end
    endtask

    task automatic test_basic_frame();
        ifs.start = 1'b1;
        run_frame("basic", 0, 0);
    endtask

    task automatic test_latency();
        int seen;
        @(negedge clk);
        ifs.start = 1'b1;
        @(negedge clk);
        ifs.start = 1'b0;
        n_vec++;
        if (ifs.mem_rd_en !== 1'b1 || ifs.mem_addr !== '0 || ifs.ifm_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_c1 rd_en/addr/valid: got %0b/%0d/%0b, expected 1/0/0",
                     ifs.mem_rd_en, ifs.mem_addr, ifs.ifm_valid);
        end
        @(negedge clk);
        n_vec++;
        if (ifs.mem_addr !== A_S'(1) || ifs.ifm_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_c2 addr/valid: got %0d/%0b, expected 1/0", ifs.mem_addr, ifs.ifm_valid);
        end
        @(negedge clk);
        n_vec++;
        if (ifs.ifm_valid !== 1'b1 || ifs.ifm !== 16'd0) begin
            n_err++;
            $display("FAIL latency_c3 valid/ifm: got %0b/%0d, expected 1/0", ifs.ifm_valid, ifs.ifm);
        end
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge clk);
            if (ifs.done === 1'b1) seen = 1;
        end
        n_vec++;
        if (seen != 1) begin
            n_err++;
            $display("FAIL latency_done_timeout: got no done, expected done within 40 cycles");
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        ifs.start = 1'b1;
        run_frame("start_busy", 7, T_S + 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if ({ifs.mem_rd_en, ifs.busy, ifs.done} !== 3'b000) begin
                n_err++;
                $display("FAIL start_busy_idle %0d rd_en/busy/done: got %b, expected 000",
                         k, {ifs.mem_rd_en, ifs.busy, ifs.done});
            end
        end
        ifs.start = 1'b1;
        run_frame("replay", 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] obs;
        ifs.start = 1'b1;
        @(negedge clk);
        ifs.start = 1'b0;
        repeat (11) @(negedge clk);
        n_vec++;
        if (ifs.mem_rd_en !== 1'b1 || ifs.mem_addr !== A_S'(9)) begin
            n_err++;
            $display("FAIL mid_reset_pre rd_en/addr: got %0b/%0d, expected 1/9", ifs.mem_rd_en, ifs.mem_addr);
        end
        rst = 1'b0;
        #1;
        obs = {ifs.mem_rd_en, ifs.mem_addr, ifs.ifm, ifs.ifm_valid, ifs.ifm_last_ch,
               ifs.gap, ifs.busy, ifs.done, 4'b0};
        n_vec++;
        if (obs !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %h, expected 0", obs);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if ({ifs.mem_rd_en, ifs.busy, ifs.done, ifs.ifm_valid} !== 4'b0000) begin
                n_err++;
                $display("FAIL mid_reset_hold %0d: got %b, expected 0000",
                         k, {ifs.mem_rd_en, ifs.busy, ifs.done, ifs.ifm_valid});
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (ifs.done !== 1'b0 || ifs.busy !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_no_done %0d done/busy: got %0b/%0b, expected 0/0",
                         k, ifs.done, ifs.busy);
            end
        end
        ifs.start = 1'b1;
        run_frame("after_reset", 0, 0);
    endtask

    task automatic test_back_to_back();
        ifs.start = 1'b1;
        run_frame("b2b_first", 0, 0);
        ifs.start = 1'b1;
        run_frame("b2b_second", 0, 0);
    endtask

    task automatic test_large_frame();
        int n_rd, n_valid, n_gap, n_done, run, data_idx;
        int first_valid, done_k, bad_data, bad_spacing, bad_excl, bad_last;
        int last_addr;
        n_rd = 0; n_valid = 0; n_gap = 0; n_done = 0; run = 0; data_idx = 0;
        first_valid = -1; done_k = -1; bad_data = 0; bad_spacing = 0; bad_excl = 0;
        bad_last = 0; last_addr = -1;
        @(negedge clk);
        ifb.start = 1'b1;
        for (int k = 1; k <= T_B + 50 && (done_k < 0 || k <= done_k + 5); k++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            if (ifb.mem_rd_en === 1'b1) begin
                n_rd++;
                last_addr = int'(ifb.mem_addr);
            end
            if (ifb.ifm_valid === 1'b1) begin
                if (first_valid < 0) first_valid = k;
                if (ifb.ifm !== 16'(data_idx)) bad_data++;
                data_idx++;
                n_valid++;
                run++;
                if (ifb.ifm_last_ch !== (run == C_B)) bad_last++;
            end else if (ifb.ifm_last_ch !== 1'b0) begin
                bad_last++;
            end
            if (ifb.gap === 1'b1) begin
                n_gap++;
                if (run != C_B) bad_spacing++;
                run = 0;
                if (ifb.ifm_valid === 1'b1) bad_excl++;
            end
            if (ifb.done === 1'b1) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
        end
        n_vec++;
        if (done_k < 0) begin
            n_err++;
            $display("FAIL large_done_timeout: got no done, expected one within %0d cycles", T_B + 50);
        end
        n_vec++;
        if (n_rd != W_B * H_B * C_B) begin
            n_err++;
            $display("FAIL large_reads: got %0d, expected %0d", n_rd, W_B * H_B * C_B);
        end
        n_vec++;
        if (n_valid != W_B * H_B * C_B) begin
            n_err++;
            $display("FAIL large_valids: got %0d, expected %0d", n_valid, W_B * H_B * C_B);
        end
        n_vec++;
        if (n_gap != W_B * H_B) begin
            n_err++;
            $display("FAIL large_gaps: got %0d, expected %0d", n_gap, W_B * H_B);
        end
        n_vec++;
        if (last_addr != W_B * H_B * C_B - 1) begin
            n_err++;
            $display("FAIL large_last_addr: got %0d, expected %0d", last_addr, W_B * H_B * C_B - 1);
        end
        n_vec++;
        if (done_k - first_valid != T_B) begin
            n_err++;
            $display("FAIL large_done_offset: got %0d, expected %0d", done_k - first_valid, T_B);
        end
        n_vec++;
        if (n_done != 1) begin
            n_err++;
            $display("FAIL large_done_count: got %0d, expected 1", n_done);
        end
        n_vec++;
        if (bad_data != 0 || bad_spacing != 0 || bad_excl != 0 || bad_last != 0) begin
            n_err++;
            $display("FAIL large_stream data/spacing/excl/last: got %0d/%0d/%0d/%0d, expected 0/0/0/0",
                     bad_data, bad_spacing, bad_excl, bad_last);
        end
        n_vec++;
        if (ifb.busy !== 1'b0) begin
            n_err++;
            $display("FAIL large_busy_end: got %0b, expected 0", ifb.busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_latency();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        test_large_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fire_ifm_streamer.md
# fire_ifm_streamer

Feature-map transmitter that feeds a 1×1 squeeze layer's serial `ifm` input. It reads a stored input feature map (W_IN×H_IN×CHIN, channel-fastest) from a synchronous single-port RAM and emits one WIDTH-bit pixel-channel value per cycle. Each pixel is one burst of CHIN channel values followed by one idle gap cycle, which matches the squeeze layer's CHIN+1-cycle accumulate/clear period. It sits between the fire-module feature-map buffer and the squeeze MAC array.

## Interface
- `WIDTH`, 16, data width of one feature-map value
- `W_IN`, 32, feature-map width in pixels
- `H_IN`, 32, feature-map height in pixels
- `CHIN`, 256, channels per pixel (≥2)
- `ADDR_W`, $clog2(W_IN*H_IN*CHIN), RAM address width

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request to stream a full frame; ignored unless idle
- `mem_rd_en`  out  1  RAM read strobe
- `mem_addr`  out  ADDR_W  RAM read address
- `mem_rdata`  in  WIDTH  RAM read data, valid the cycle after `mem_rd_en`
- `ifm`  out  WIDTH  streamed value (registered)
- `ifm_valid`  out  1  `ifm` carries a valid value this cycle
- `ifm_last_ch`  out  1  `ifm` is channel CHIN-1 of the current pixel
- `gap`  out  1  pixel-boundary idle cycle, high the cycle after `ifm_last_ch`
- `busy`  out  1  frame in progress (start accepted, done not yet pulsed)
- `done`  out  1  one-cycle pulse after the last gap of the frame

## Operation
- Address order: `mem_addr = (row*W_IN + col)*CHIN + ch`; ch fastest, then col, then row; unsigned, no wrap within a frame.
- FSM states: IDLE, READ, GAP, DRAIN.
  - IDLE: outputs quiet; `start`=1 → READ with ch=col=row=0, `busy`←1.
  - READ: `mem_rd_en`=1 and `mem_addr` = current address every cycle; ch increments. After the read with ch=CHIN-1 → GAP, ch←0.
  - GAP: `mem_rd_en`=0 for exactly one cycle. Advance col, and row when col wraps from W_IN-1 to 0. If the pixel just read was (H_IN-1, W_IN-1) → DRAIN; else → READ.
  - DRAIN: 2 cycles with no reads so the output pipeline empties, then → IDLE with `done`=1 for one cycle and `busy`←0.
- Output pipeline has 2 register stages: stage 1 captures the read tag (valid, last_ch, gap); stage 2 drives `ifm`←`mem_rdata` together with the delayed tags. `ifm_valid`, `ifm_last_ch` and `gap` stay mutually aligned with `ifm`.
- `ifm` holds its last value while `ifm_valid`=0, so a consumer that samples every cycle sees a stable value during the gap.
- `start` while busy: ignored; no restart, counters undisturbed.
- `start` in the same cycle as `done`: ignored. A new frame needs `start` after `busy`=0.
- Reset, including mid-frame: asynchronous. FSM→IDLE, counters→0, pipeline flushed. No `done` is issued for the aborted frame.
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `ifm`=0, `ifm_valid`=0, `ifm_last_ch`=0, `gap`=0, `busy`=0, `done`=0.

## Timing
- Edge E0 samples `start`=1. The first `mem_rd_en` is in the cycle after E0, and the first `ifm_valid` comes 2 cycles after the first read.
- Per pixel: CHIN cycles with `ifm_valid`=1, then 1 cycle with `gap`=1, giving a period of CHIN+1 with no other bubbles.
- Frame length: W_IN*H_IN*(CHIN+1) stream cycles. For defaults, 1024*257 = 263168.
- `done` is high exactly 1 cycle after the final `gap` output cycle, and `busy` falls in that same cycle.
- `ifm_valid` and `gap` are never high together. `ifm_last_ch` implies `ifm_valid`.

## Test plan
- Basic frame: W_IN=2, H_IN=2, CHIN=4, RAM model rdata=address, pulse `start` → `ifm` sequence 0,1,2,3,gap,4,5,6,7,gap,…,12..15,gap. 16 valid cycles, 4 gaps, `ifm_last_ch` on values 3/7/11/15, `done` 1 cycle after the last gap (20 stream cycles).
- Latency and addresses: same config → first `mem_rd_en` one cycle after the `start` edge with `mem_addr`=0; first `ifm_valid` 2 cycles later; `mem_addr` skips nothing and `mem_rd_en`=0 on gap cycles.
- Start while busy: pulse `start` again mid-frame and in the `done` cycle → stream unchanged, single `done`, `busy` low afterwards; a later `start` replays the frame from address 0.
- Reset mid-frame: deassert `rst` during pixel 2 ch 1 → all outputs 0 immediately, no `done`; after release plus `start`, the stream restarts at address 0.
- Default params: W_IN=32, H_IN=32, CHIN=256 → 262144 valid cycles, 1024 gaps, last `mem_addr`=262143, `done` 263168 cycles after the first valid plus pipeline offset.
- Back-to-back frames: `start` in the first cycle after `busy`=0 → second frame identical; gap spacing inside each frame is always exactly CHIN valid cycles.
